radar_azimuth_tracker: RTL and testbench
========================================

Name: radar_azimuth_tracker

Overview:
- Downstream consumer of radar_statistics.
- Once the statistics block reports CALIBRATED, this block locks onto the antenna rotation and tracks the current azimuth (ACP index since the last ARP) and the current range time (microseconds since the last TRIG).
- On every TRIG it emits a one-cycle sweep record carrying the azimuth of that sweep.
- It flags missed ARP and missed TRIG events, giving the simulator a per-sweep azimuth/range time base.

Parameters:
- DATA_WIDTH, 32: width of the statistics inputs and of all counter outputs.
- MAX_MISS, 2: consecutive missed ARPs tolerated before lock is dropped (range 1..15).
- TRIG_TOL, 2: extra microseconds beyond the latched TRIG period before a TRIG is declared missed.

Ports:
- SYS_CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- ARP  in  1  raw azimuth reference pulse, level input.
- ACP  in  1  raw azimuth change pulse, level input.
- TRIG  in  1  raw radar trigger, level input.
- USEC  in  1  1 MHz microsecond tick, level input.
- CALIBRATED  in  1  from radar_statistics: ACP_CNT and TRIG_US are valid.
- ACP_CNT  in  DATA_WIDTH  ACPs per revolution.
- TRIG_US  in  DATA_WIDTH  TRIG period in microseconds.
- LOCKED  out  1  high while in TRACK.
- AZIMUTH  out  DATA_WIDTH  ACP index since the last ARP.
- RANGE_US  out  DATA_WIDTH  microseconds since the last TRIG.
- SWEEP_VALID  out  1  one-cycle pulse per TRIG while LOCKED.
- SWEEP_AZ  out  DATA_WIDTH  azimuth of the sweep; valid with SWEEP_VALID, held otherwise.
- ERR_ARP  out  1  one-cycle pulse when azimuth wraps without an ARP.
- ERR_TRIG  out  1  one-cycle pulse when a TRIG is missed.

Behaviour:
- Reset: all outputs 0, all internal registers 0, state IDLE. RST mid-operation aborts tracking in the same edge.
- Input conditioning:
  - ARP, ACP, TRIG and USEC each pass through a 2-FF synchronizer plus a previous-value register (all reset to 0).
  - A rising-edge pulse is s2 & ~s3.
  - An input first sampled high at edge n gives an edge pulse in the cycle after edge n+1; the dependent output updates at edge n+2.
  - A level already high at reset release counts as an edge; it is harmless because only WAIT_ARP and TRACK act on edges.
- FSM:
  - IDLE: outputs held at 0. Go to WAIT_ARP when CALIBRATED=1 and ACP_CNT!=0 and TRIG_US!=0.
  - WAIT_ARP:
    - On an ARP edge: latch ACP_CNT into acp_max and TRIG_US into trig_max, set AZIMUTH=0, RANGE_US=0, miss count=0, go to TRACK.
    - If CALIBRATED drops, go to IDLE.
  - TRACK: LOCKED=1.
    - If CALIBRATED drops, go to IDLE, clearing AZIMUTH and RANGE_US.
    - If the miss count reaches MAX_MISS, go to WAIT_ARP; AZIMUTH and RANGE_US hold their values.
- Azimuth in TRACK:
  - ARP edge: AZIMUTH=0 and miss count=0. This applies even if an ACP edge occurs in the same cycle (ARP wins).
  - ACP edge without ARP:
    - If AZIMUTH == acp_max-1: AZIMUTH=0, ERR_ARP=1 for one cycle, miss count +1.
    - Otherwise: AZIMUTH+1.
- Range in TRIG edge cycles (TRACK):
  - RANGE_US=0.
  - SWEEP_VALID=1.
  - SWEEP_AZ = the AZIMUTH value after same-cycle ARP/ACP updates are applied.
  - TRIG wins over a same-cycle USEC edge.
- Range in USEC edge cycles without TRIG (TRACK):
  - RANGE_US saturates at 2^DATA_WIDTH-1.
  - When RANGE_US+1 == trig_max+TRIG_TOL, ERR_TRIG=1 for exactly one cycle. It does not repeat while RANGE_US continues to count.
- Width and arithmetic: all comparisons are unsigned at DATA_WIDTH. The trig_max+TRIG_TOL sum is computed at DATA_WIDTH+1 bits, so it cannot wrap.
- Changes on ACP_CNT and TRIG_US while in TRACK are ignored until the next entry into WAIT_ARP.
- SWEEP_VALID, ERR_ARP and ERR_TRIG are never asserted outside TRACK.

Test Plan:
- Reset and idle: hold RST for 3 cycles with CALIBRATED=0 and inputs toggling -> all outputs 0 and LOCKED=0 throughout.
- Lock-on:
  - Stimulus: CALIBRATED=1, ACP_CNT=5, TRIG_US=5, then an ARP edge.
  - Response: LOCKED=1 two edges after the ARP is sampled high; AZIMUTH=0.
  - Then 4 ACP edges -> AZIMUTH steps 1,2,3,4.
- Coincident ARP+ACP: assert both edges in the same cycle with AZIMUTH=4 -> AZIMUTH=0 and ERR_ARP stays 0.
- Missed ARP:
  - Stimulus: acp_max=5, 5 ACP edges without ARP.
  - Response: AZIMUTH wraps to 0 and ERR_ARP pulses once.
  - With MAX_MISS=2, a second missed revolution -> LOCKED=0 (state WAIT_ARP).
  - A following ARP edge -> relock with AZIMUTH=0.
- Sweep record:
  - Stimulus: AZIMUTH=3, 4 USEC edges, then a TRIG edge coincident with a USEC edge.
  - Response: RANGE_US reaches 4; then SWEEP_VALID pulses 1 cycle with SWEEP_AZ=3 and RANGE_US=0.
- Missed TRIG and calibration loss:
  - Stimulus: trig_max=5, TRIG_TOL=2, 9 USEC edges with no TRIG.
  - Response: ERR_TRIG pulses once, when RANGE_US becomes 7; RANGE_US ends at 9.
  - Then drop CALIBRATED -> IDLE next edge, with AZIMUTH=0 and RANGE_US=0.

Source files
------------

// File: rtl/radar_azimuth_tracker.sv
// radar_azimuth_tracker: locks onto antenna rotation and tracks azimuth/range time per sweep
module radar_azimuth_tracker #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_MISS   = 2,
  parameter int TRIG_TOL   = 2
) (
  input  logic                  SYS_CLK,
  input  logic                  RST,
  input  logic                  ARP,
  input  logic                  ACP,
  input  logic                  TRIG,
  input  logic                  USEC,
  input  logic                  CALIBRATED,
  input  logic [DATA_WIDTH-1:0] ACP_CNT,
  input  logic [DATA_WIDTH-1:0] TRIG_US,
  output logic                  LOCKED,
  output logic [DATA_WIDTH-1:0] AZIMUTH,
  output logic [DATA_WIDTH-1:0] RANGE_US,
  output logic                  SWEEP_VALID,
  output logic [DATA_WIDTH-1:0] SWEEP_AZ,
  output logic                  ERR_ARP,
  output logic                  ERR_TRIG
);
  localparam int W = DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, WAIT_ARP, TRACK} state_t;
  state_t state, state_n;
  logic [3:0] s1, s2, s3, e;
  logic arp_e, acp_e, trig_e, usec_e;
  logic [W-1:0] acp_max, trig_max, acp_max_n, trig_max_n, az_n, rng_n, saz_n;
  logic [3:0] miss, miss_n;
  logic sv_n, ea_n, et_n;
  logic [W:0] trig_lim, rng_inc;
  assign e = s2 & ~s3;
  assign {arp_e, acp_e, trig_e, usec_e} = e;
  assign trig_lim = {1'b0, trig_max} + (W+1)'(TRIG_TOL);
  assign rng_inc = {1'b0, RANGE_US} + (W+1)'(1);
  assign LOCKED = state == TRACK;
  // next-state and next-value logic; an ARP beats an ACP, a TRIG beats a USEC
  always_comb begin
    state_n = state;
    az_n = AZIMUTH;
    rng_n = RANGE_US;
    saz_n = SWEEP_AZ;
    acp_max_n = acp_max;
    trig_max_n = trig_max;
    miss_n = miss;
    sv_n = 1'b0;
    ea_n = 1'b0;
    et_n = 1'b0;
    case (state)
      WAIT_ARP: begin
        if (!CALIBRATED) begin
          state_n = IDLE;
          az_n = '0;
          rng_n = '0;
          saz_n = '0;
        end else if (arp_e) begin
          state_n = TRACK;
          acp_max_n = ACP_CNT;
          trig_max_n = TRIG_US;
          az_n = '0;
          rng_n = '0;
          miss_n = '0;
        end
      end
      TRACK: begin
        if (!CALIBRATED) begin
          state_n = IDLE;
          az_n = '0;
          rng_n = '0;
          saz_n = '0;
        end else begin
          if (arp_e) begin
            az_n = '0;
            miss_n = '0;
          end else if (acp_e) begin
            if (AZIMUTH == acp_max - 1'b1) begin
              az_n = '0;
              ea_n = 1'b1;
              miss_n = miss + 4'd1;
            end else az_n = AZIMUTH + 1'b1;
          end
          if (trig_e) begin
            rng_n = '0;
            sv_n = 1'b1;
            saz_n = az_n;
          end else if (usec_e && !(&RANGE_US)) begin
            rng_n = rng_inc[W-1:0];
            et_n = rng_inc == trig_lim;
          end
          if (miss_n == 4'(MAX_MISS)) state_n = WAIT_ARP;
        end
      end
      default: begin
        az_n = '0;
        rng_n = '0;
        saz_n = '0;
        if (CALIBRATED && |ACP_CNT && |TRIG_US) state_n = WAIT_ARP;
      end
    endcase
  end
  // input synchronizers, edge history and all tracking state
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      {s1, s2, s3} <= '0;
      state <= IDLE;
      {AZIMUTH, RANGE_US, SWEEP_AZ, acp_max, trig_max} <= '0;
      miss <= '0;
      {SWEEP_VALID, ERR_ARP, ERR_TRIG} <= '0;
    end else begin
      s1 <= {ARP, ACP, TRIG, USEC};
      s2 <= s1;
      s3 <= s2;
      state <= state_n;
      AZIMUTH <= az_n;
      RANGE_US <= rng_n;
      SWEEP_AZ <= saz_n;
      acp_max <= acp_max_n;
      trig_max <= trig_max_n;
      miss <= miss_n;
      {SWEEP_VALID, ERR_ARP, ERR_TRIG} <= {sv_n, ea_n, et_n};
    end
  end
endmodule

// File: tb/tb_radar_azimuth_tracker.sv
// tb_radar_azimuth_tracker: directed scoreboard bench for radar_azimuth_tracker
module tb_radar_azimuth_tracker;
  localparam int W = 32;
  typedef struct {logic [2:0] f; logic [W-1:0] v;} exp_t;
  logic SYS_CLK = 1'b0, RST = 1'b1;
  logic ARP = 1'b0, ACP = 1'b0, TRIG = 1'b0, USEC = 1'b0, CALIBRATED = 1'b0;
  logic [W-1:0] ACP_CNT = '0, TRIG_US = '0;
  logic LOCKED, SWEEP_VALID, ERR_ARP, ERR_TRIG;
  logic [W-1:0] AZIMUTH, RANGE_US, SWEEP_AZ;
  int checks = 0, failures = 0;
  exp_t q[$];
  radar_azimuth_tracker #(.DATA_WIDTH(W), .MAX_MISS(2), .TRIG_TOL(2)) dut (
    .SYS_CLK(SYS_CLK), .RST(RST), .ARP(ARP), .ACP(ACP), .TRIG(TRIG), .USEC(USEC),
    .CALIBRATED(CALIBRATED), .ACP_CNT(ACP_CNT), .TRIG_US(TRIG_US), .LOCKED(LOCKED),
    .AZIMUTH(AZIMUTH), .RANGE_US(RANGE_US), .SWEEP_VALID(SWEEP_VALID), .SWEEP_AZ(SWEEP_AZ),
    .ERR_ARP(ERR_ARP), .ERR_TRIG(ERR_TRIG)
  );
  always #5 SYS_CLK = ~SYS_CLK;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask
  // one-cycle pulse on {ARP,ACP,TRIG,USEC}; returns once the resulting update is visible
  task automatic ev(input logic [3:0] m);
    {ARP, ACP, TRIG, USEC} = m;
    @(negedge SYS_CLK);
    {ARP, ACP, TRIG, USEC} = 4'b0;
    @(negedge SYS_CLK);
    @(negedge SYS_CLK);
  endtask
  // monitor: every pulse output must match the next queued expectation
  always @(negedge SYS_CLK) begin
    if (SWEEP_VALID || ERR_ARP || ERR_TRIG) begin
      exp_t x;
      logic [W-1:0] v;
      v = SWEEP_VALID ? SWEEP_AZ : ERR_TRIG ? RANGE_US : AZIMUTH;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event got flags=%b val=%0d want none", {SWEEP_VALID, ERR_ARP, ERR_TRIG}, v);
      end else begin
        x = q.pop_front();
        if ({SWEEP_VALID, ERR_ARP, ERR_TRIG} !== x.f || v !== x.v) begin
          failures++;
          $display("FAIL event got flags=%b val=%0d want flags=%b val=%0d", {SWEEP_VALID, ERR_ARP, ERR_TRIG}, v, x.f, x.v);
        end
      end
    end
  end
  initial begin
    for (int i = 0; i < 3; i++) begin
      @(negedge SYS_CLK);
      {ARP, ACP, TRIG, USEC} = 4'(i + 5);
      @(negedge SYS_CLK);
      chk("reset_outputs", {LOCKED, AZIMUTH, RANGE_US, SWEEP_VALID, SWEEP_AZ, ERR_ARP, ERR_TRIG}, '0);
    end
    {ARP, ACP, TRIG, USEC} = 4'b0;
    @(negedge SYS_CLK);
    RST = 1'b0;
    repeat (4) @(negedge SYS_CLK);
    chk("idle_locked", LOCKED, 0);
    CALIBRATED = 1'b1;
    ACP_CNT = 5;
    TRIG_US = 5;
    repeat (3) @(negedge SYS_CLK);
    chk("wait_arp_unlocked", LOCKED, 0);
    ev(4'b1000);
    chk("lock_locked", LOCKED, 1);
    chk("lock_az", AZIMUTH, 0);
    for (int i = 1; i <= 4; i++) begin
      ev(4'b0100);
      chk("az_step", AZIMUTH, 128'(i));
    end
    ev(4'b1100);
    chk("arp_acp_az", AZIMUTH, 0);
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) q.push_back('{3'b010, 0});
      ev(4'b0100);
      chk("miss1_az", AZIMUTH, 128'(i % 5));
    end
    chk("miss1_locked", LOCKED, 1);
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) q.push_back('{3'b010, 0});
      ev(4'b0100);
      chk("miss2_az", AZIMUTH, 128'(i % 5));
    end
    chk("miss2_unlocked", LOCKED, 0);
    ev(4'b0100);
    chk("wait_arp_acp_ignored", AZIMUTH, 0);
    ev(4'b1000);
    chk("relock_locked", LOCKED, 1);
    chk("relock_az", AZIMUTH, 0);
    for (int i = 1; i <= 3; i++) ev(4'b0100);
    chk("sweep_pre_az", AZIMUTH, 3);
    for (int i = 1; i <= 4; i++) begin
      ev(4'b0001);
      chk("range_step", RANGE_US, 128'(i));
    end
    q.push_back('{3'b100, 3});
    ev(4'b0011);
    chk("sweep_range", RANGE_US, 0);
    chk("sweep_az_hold", SWEEP_AZ, 3);
    for (int i = 1; i <= 9; i++) begin
      if (i == 7) q.push_back('{3'b001, 7});
      ev(4'b0001);
      chk("miss_trig_range", RANGE_US, 128'(i));
    end
    CALIBRATED = 1'b0;
    @(negedge SYS_CLK);
    chk("cal_drop", {LOCKED, AZIMUTH, RANGE_US}, '0);
    ev(4'b0010);
    ev(4'b1100);
    chk("idle_quiet", {LOCKED, AZIMUTH, RANGE_US}, '0);
    repeat (3) @(negedge SYS_CLK);
    chk("queue_drained", 128'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
